// File: rtl/seq_det_prog.sv
// ---------------------------------------------------------------------------
// seq_det_prog
//
// Programmable serial pattern detector. A pattern of 2..PAT_W bits is held in
// a register and compared against the most recently sampled serial bits.
// Each match produces a one-cycle registered pulse on det_o. Detection can
// either allow successive matches to share bits (overlapping) or require
// every match to be built from fresh bits (non-overlapping).
//
// An optional saturating match counter is built only when the macro
// SEQ_DET_PROG_CNT_EN is defined. Without it, match_cnt is a constant zero,
// count_clr is ignored and no counter flops exist.
//
// Parameters
//   PAT_W    maximum pattern length in bits (2..16)
//   CNT_W    match counter width
//   PAT_RST  pattern loaded by reset (only the low PAT_W bits are used)
//   LEN_RST  pattern length loaded by reset (clipped to 2..PAT_W)
//
// Ports
//   clock       in   1      sole clock, rising edge
//   reset_n     in   1      asynchronous active-low reset
//   seq_in      in   1      serial data bit
//   in_valid    in   1      seq_in is sampled this cycle
//   overlap_en  in   1      1 = overlapping, 0 = non-overlapping detection
//   pat_load    in   1      load pat_value / pat_len this cycle
//   pat_value   in   PAT_W  pattern, bit [len-1] is received first
//   pat_len     in   5      requested pattern length
//   count_clr   in   1      synchronous clear of match_cnt
//   det_o       out  1      registered one-cycle match pulse
//   match_cnt   out  CNT_W  saturating match count
// ---------------------------------------------------------------------------
module seq_det_prog #(
    parameter int          PAT_W   = 8,
    parameter int          CNT_W   = 8,
    parameter logic [15:0] PAT_RST = 16'h0005,
    parameter int          LEN_RST = 3
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             seq_in,
    input  logic             in_valid,
    input  logic             overlap_en,
    input  logic             pat_load,
    input  logic [PAT_W-1:0] pat_value,
    input  logic [4:0]       pat_len,
    input  logic             count_clr,
    output logic             det_o,
    output logic [CNT_W-1:0] match_cnt
);

    // Wide enough to hold the value PAT_W itself, since fill and length
    // both range up to and including PAT_W.
    localparam int LEN_W = $clog2(PAT_W + 1);

    // Reset length gets the same clipping as a run-time load.
    localparam int LEN_RST_CLIP = (LEN_RST < 2)     ? 2     :
                                  (LEN_RST > PAT_W) ? PAT_W : LEN_RST;

    localparam logic [LEN_W-1:0] LEN_RST_V = LEN_W'(LEN_RST_CLIP);
    localparam logic [PAT_W-1:0] PAT_RST_V = PAT_RST[PAT_W-1:0];

    logic [PAT_W-1:0] pat_q,  pat_d;
    logic [LEN_W-1:0] len_q,  len_d;
    logic [PAT_W-1:0] hist_q, hist_d;
    logic [LEN_W-1:0] fill_q, fill_d;
    logic             det_q,  det_d;

    logic [LEN_W-1:0] len_load;
    logic [PAT_W-1:0] len_mask;
    logic [PAT_W-1:0] hist_shift;
    logic [LEN_W-1:0] fill_inc;
    logic             match;

    // Clip the requested length into the legal 2..PAT_W window. pat_len is
    // five bits wide so it can ask for more than PAT_W; it is compared as
    // an integer before being narrowed to avoid losing the upper bits.
    always_comb begin
        len_load = len_q;
        if (pat_len < 5'd2) begin
            len_load = LEN_W'(2);
        end else if (int'(pat_len) > PAT_W) begin
            len_load = LEN_W'(PAT_W);
        end else begin
            len_load = LEN_W'(pat_len);
        end
    end

    // Thermometer mask selecting the low len_q bits of history and pattern,
    // so only the active part of the pattern takes part in the compare.
    always_comb begin
        len_mask = '0;
        for (int i = 0; i < PAT_W; i++) begin
            len_mask[i] = (i < int'(len_q));
        end
    end

    // Candidate history and fill count if the current bit is sampled. A
    // match needs the fill count to reach the pattern length, so bits
    // left over from before a load, reset or non-overlapping match can
    // never complete a pattern.
    always_comb begin
        hist_shift = {hist_q[PAT_W-2:0], seq_in};
        fill_inc   = (fill_q < len_q) ? (fill_q + LEN_W'(1)) : len_q;
        match      = 1'b0;
        if (!pat_load && in_valid && (fill_inc == len_q) &&
            (((hist_shift ^ pat_q) & len_mask) == '0)) begin
            match = 1'b1;
        end
    end

    // Next-state selection. A pattern load takes priority and discards the
    // sampled bit of that cycle; otherwise a valid bit shifts into history.
    // On a match the fill count either stays full (the pattern's tail can
    // start the next match) or restarts from zero (no shared bits).
    always_comb begin
        pat_d  = pat_q;
        len_d  = len_q;
        hist_d = hist_q;
        fill_d = fill_q;
        det_d  = 1'b0;
        if (pat_load) begin
            pat_d  = pat_value;
            len_d  = len_load;
            fill_d = '0;
        end else if (in_valid) begin
            hist_d = hist_shift;
            if (match) begin
                det_d  = 1'b1;
                fill_d = overlap_en ? len_q : '0;
            end else begin
                fill_d = fill_inc;
            end
        end
    end

    // Detector state registers. Reset restores the default pattern and
    // empties the history so a partial sequence cannot survive it.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pat_q  <= PAT_RST_V;
            len_q  <= LEN_RST_V;
            hist_q <= '0;
            fill_q <= '0;
            det_q  <= 1'b0;
        end else begin
            pat_q  <= pat_d;
            len_q  <= len_d;
            hist_q <= hist_d;
            fill_q <= fill_d;
            det_q  <= det_d;
        end
    end

    assign det_o = det_q;

`ifdef SEQ_DET_PROG_CNT_EN

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Saturating match counter. A clear coinciding with a match leaves the
    // count at one so that match is not lost. Pattern loads never produce
    // a match, so they leave the count untouched.
    always_comb begin
        cnt_d = cnt_q;
        if (count_clr) begin
            cnt_d = match ? CNT_W'(1) : '0;
        end else if (match && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign match_cnt = cnt_q;

`else

    // Counter omitted: the output is a constant and the clear input is
    // deliberately left without a load.
    logic unused_count_clr;
    assign unused_count_clr = count_clr;
    assign match_cnt        = '0;

`endif

endmodule

// File: tb/tb_seq_det_prog.sv
// ---------------------------------------------------------------------------
// tb_seq_det_prog
//
// Bench for seq_det_prog (PAT_W=8, CNT_W=2). Expected det_o / match_cnt
// values come from a bit-queue reference model and are queued per cycle;
// a monitor compares them one cycle later. Expected counter values follow
// the SEQ_DET_PROG_CNT_EN macro (zero when the counter is not built).
// ---------------------------------------------------------------------------
module tb_seq_det_prog;

    localparam int PatW   = 8;
    localparam int CntW   = 2;
    localparam int CntMax = 3;

`ifdef SEQ_DET_PROG_CNT_EN
    localparam bit CntEn = 1'b1;
`else
    localparam bit CntEn = 1'b0;
`endif

    logic            clock;
    logic            reset_n;
    logic            seq_in;
    logic            in_valid;
    logic            overlap_en;
    logic            pat_load;
    logic [PatW-1:0] pat_value;
    logic [4:0]      pat_len;
    logic            count_clr;
    logic            det_o;
    logic [CntW-1:0] match_cnt;

    typedef struct {
        bit    det;
        int    cnt;
        string tag;
    } exp_t;

    exp_t expQ[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model state: the bits sampled since the last boundary
    // (reset, pattern load or non-overlapping match), the pattern and the
    // clipped length, and the ideal match count.
    bit              modelBits[$];
    logic [PatW-1:0] modelPat;
    int              modelLen;
    int              modelCnt;

    seq_det_prog #(
        .PAT_W  (PatW),
        .CNT_W  (CntW),
        .PAT_RST(16'h0005),
        .LEN_RST(3)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .seq_in    (seq_in),
        .in_valid  (in_valid),
        .overlap_en(overlap_en),
        .pat_load  (pat_load),
        .pat_value (pat_value),
        .pat_len   (pat_len),
        .count_clr (count_clr),
        .det_o     (det_o),
        .match_cnt (match_cnt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic int clipLen(input int l);
        if (l < 2) return 2;
        if (l > PatW) return PatW;
        return l;
    endfunction

    // The newest modelLen bits, oldest first, must equal pattern bits
    // modelLen-1 down to 0.
    function automatic bit modelMatch();
        int n;
        n = modelBits.size();
        if (n < modelLen) return 1'b0;
        for (int k = 0; k < modelLen; k++) begin
            if (modelBits[n - modelLen + k] != modelPat[modelLen - 1 - k]) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic modelReset();
        modelBits.delete();
        modelPat = 8'h05;
        modelLen = 3;
        modelCnt = 0;
    endtask

    task automatic checkOutput(input string tag, input bit expDet, input int expCnt);
        checks++;
        if (det_o !== expDet || match_cnt !== CntW'(expCnt)) begin
            errors++;
            $display("[TB] FAIL %s: got det_o=%0b match_cnt=%0d, expected det_o=%0b match_cnt=%0d",
                     tag, det_o, match_cnt, expDet, expCnt);
        end
    endtask

    // Drive one cycle of inputs on the falling edge and queue the response
    // expected after the following rising edge.
    task automatic applyStimulus(input string tag, input bit load, input logic [PatW-1:0] val,
                                 input int len, input bit valid, input bit b,
                                 input bit ovl, input bit clr);
        exp_t e;
        bit   hit;
        @(negedge clock);
        pat_load   = load;
        pat_value  = val;
        pat_len    = 5'(len);
        in_valid   = valid;
        seq_in     = b;
        overlap_en = ovl;
        count_clr  = clr;
        hit = 1'b0;
        if (load) begin
            modelPat = val;
            modelLen = clipLen(len);
            modelBits.delete();
        end else if (valid) begin
            modelBits.push_back(b);
            if (modelBits.size() > 40) void'(modelBits.pop_front());
            hit = modelMatch();
            if (hit && !ovl) modelBits.delete();
        end
        if (clr) modelCnt = hit ? 1 : 0;
        else if (hit && modelCnt < CntMax) modelCnt++;
        e.det = hit;
        e.cnt = CntEn ? modelCnt : 0;
        e.tag = tag;
        expQ.push_back(e);
    endtask

    // Feed n bits, most significant first.
    task automatic sendBits(input string tag, input logic [15:0] bits, input int n, input bit ovl);
        for (int i = n - 1; i >= 0; i--) begin
            applyStimulus(tag, 1'b0, '0, 0, 1'b1, bits[i], ovl, 1'b0);
        end
    endtask

    // Assert reset away from the clock edge, confirm the outputs clear at
    // once, then release and confirm the release edge produces no pulse.
    task automatic doReset(input string tag);
        @(negedge clock);
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        pat_load  = 1'b0;
        count_clr = 1'b0;
        #1;
        checkOutput({tag, " async"}, 1'b0, 0);
        modelReset();
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock);
        #2;
        checkOutput({tag, " release"}, 1'b0, 0);
    endtask

    // Monitor: compare the DUT against the oldest queued expectation just
    // after each rising edge.
    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clock);
            #1;
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                checkOutput(e.tag, e.det, e.cnt);
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin : watchdog
        #2000000;
        errors++;
        $display("[TB] FAIL watchdog: time limit reached, got running, expected finished");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stimulus
        int len;
        reset_n    = 1'b0;
        seq_in     = 1'b0;
        in_valid   = 1'b0;
        overlap_en = 1'b1;
        pat_load   = 1'b0;
        pat_value  = '0;
        pat_len    = '0;
        count_clr  = 1'b0;
        modelReset();
        repeat (2) @(negedge clock);
        #1;
        checkOutput("power-on reset", 1'b0, 0);
        @(negedge clock);
        reset_n = 1'b1;

        // Default pattern 101, overlapping: matches on bits 3 and 5.
        sendBits("default overlap", 16'b10101, 5, 1'b1);
        applyStimulus("default overlap idle", 1'b0, '0, 0, 1'b0, 1'b1, 1'b1, 1'b0);

        // Same stream, non-overlapping: only bit 3 matches.
        doReset("reset A");
        sendBits("default no-overlap", 16'b10101, 5, 1'b0);
        applyStimulus("no-overlap idle", 1'b0, '0, 0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Pattern 1101 length 4, overlapping: matches on bits 4 and 7.
        doReset("reset B");
        applyStimulus("load 1101", 1'b1, 8'b1101, 4, 1'b1, 1'b1, 1'b1, 1'b0);
        sendBits("pattern 1101", 16'b1101101, 7, 1'b1);

        // Gap of invalid cycles between bits 2 and 3.
        doReset("reset C");
        sendBits("gap head", 16'b10, 2, 1'b1);
        for (int i = 0; i < 3; i++) begin
            applyStimulus("gap idle", 1'b0, '0, 0, 1'b0, 1'($urandom_range(0, 1)), 1'b1, 1'b0);
        end
        sendBits("gap tail", 16'b1, 1, 1'b1);

        // Five matches saturate the 2-bit counter, then clear with a match.
        doReset("reset D");
        sendBits("saturate", 16'b10101010101, 11, 1'b1);
        applyStimulus("saturate hold", 1'b0, '0, 0, 1'b1, 1'b0, 1'b1, 1'b0);
        applyStimulus("clear with match", 1'b0, '0, 0, 1'b1, 1'b1, 1'b1, 1'b1);
        applyStimulus("after clear", 1'b0, '0, 0, 1'b0, 1'b0, 1'b1, 1'b0);

        // Reset mid-sequence discards the partial 1,0.
        doReset("reset E");
        sendBits("partial", 16'b10, 2, 1'b1);
        doReset("reset mid-sequence");
        sendBits("after mid reset", 16'b1, 1, 1'b1);

        // Length clipping: 1 becomes 2, 20 becomes 8.
        applyStimulus("load len 1", 1'b1, 8'b10, 1, 1'b0, 1'b0, 1'b1, 1'b0);
        sendBits("len 1 clipped", 16'b0110, 4, 1'b1);
        applyStimulus("load len 20", 1'b1, 8'hA5, 20, 1'b0, 1'b0, 1'b1, 1'b0);
        sendBits("len 20 clipped", 16'hA5A5, 16, 1'b1);
        applyStimulus("load in_valid ignored", 1'b1, 8'b011, 3, 1'b1, 1'b0, 1'b1, 1'b0);
        sendBits("after ignored bit", 16'b11, 2, 1'b1);
        sendBits("after ignored bit", 16'b011, 3, 1'b1);

        // Randomized traffic with short patterns so matches are frequent.
        doReset("reset random");
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 39) == 0) begin
                len = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 31))
                                                  : int'($urandom_range(0, 5));
                applyStimulus("random load", 1'b1, 8'($urandom), len,
                              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1, 1'b0);
            end else if ($urandom_range(0, 199) == 0) begin
                doReset("random reset");
            end else begin
                applyStimulus("random bit", 1'b0, '0, 0,
                              ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                              1'($urandom_range(0, 1)), ($urandom_range(0, 29) == 0));
            end
        end

        repeat (3) @(negedge clock);
        checks++;
        if (expQ.size() != 0) begin
            errors++;
            $display("[TB] FAIL drain: got %0d pending expectations, expected 0", expQ.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
